jump_addr_fetch_seq: RTL
========================

// Module: jump_addr_fetch_seq
// PURPOSE
//  Sequencer upstream of the J1/J2 jump-address registers: on a GOTO/CALL opcode it fetches
//  the two immediate operand bytes at PC and PC+1 and presents each byte on j_data.
//  It pulses ldJ1 (high byte), then ldJ2 (low byte), steps PC after each byte and, if the
//  jump is taken, pulses ld_pc_from_j. Sits between the decoder/memory and the register unit.
// PARAMETERS
//  AW  16  address width (PC, address bus)
//  DW  8   data width (memory byte, J1/J2 width)
// PORTS
//  clk           in   1   system clock, all state changes on rising edge
//  rst_n         in   1   synchronous active-low reset
//  start         in   1   decoder request: begin operand fetch (sampled only in IDLE)
//  cond_ok       in   1   jump-taken qualifier, latched on start acceptance
//  pc_in         in   AW  current program counter
//  addr_out      out  AW  address driven toward memory (valid while addr_drv=1)
//  addr_drv      out  1   address bus enable
//  mem_rd        out  1   memory read request, held until mem_ack
//  mem_ack       in   1   memory read done; mem_data valid in the same cycle
//  mem_data      in   DW  memory read data
//  j_data        out  DW  captured operand byte to the J register data input
//  ldJ1          out  1   one-cycle load strobe, J1 (high byte)
//  ldJ2          out  1   one-cycle load strobe, J2 (low byte)
//  inc_pc        out  1   one-cycle PC increment strobe
//  ld_pc_from_j  out  1   one-cycle strobe: PC <= {J1,J2}
//  busy          out  1   high in every non-IDLE state
//  done          out  1   one-cycle completion pulse
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE; j_data=0; taken=0; every strobe, addr_drv,
//    mem_rd, busy and done=0. Applies mid-operation. A pending mem_rd is dropped. No partial
//    strobes are issued after reset.
//  - States: IDLE, RD1, LD1, INC1, RD2, LD2, INC2, [SAVE], JMP, DONE.
//  - IDLE: start=1 -> RD1, taken<=cond_ok. start is ignored in every other state (no queuing).
//  - RD1/RD2: addr_drv=1, addr_out=pc_in, mem_rd=1. Wait while mem_ack=0.
//    On mem_ack=1: j_data<=mem_data; RD1 -> LD1, RD2 -> LD2.
//  - LD1: ldJ1=1 -> INC1. LD2: ldJ2=1 -> INC2. j_data holds its value through the strobe cycle.
//  - INC1: inc_pc=1 -> RD2. PC updates externally before RD2 samples pc_in.
//  - INC2: inc_pc=1. If taken -> (SAVE if enabled) else JMP. If not taken -> DONE.
//  - JMP: ld_pc_from_j=1 -> DONE. DONE: done=1 -> IDLE. busy=0 in the DONE->IDLE cycle after.
//  - Strobes are mutually exclusive and exactly one cycle wide. Outputs are registered from state.
//  - mem_ack outside RD1/RD2 is ignored. j_data is not cleared between operations.
//  - Latency with zero-wait mem_ack, counted from the start-accept edge to done high:
//    taken 8 cycles, not-taken 7 cycles. Each mem_ack wait cycle adds 1.
//  - Not taken: PC still advances by 2 (operands skipped). J1/J2 are still loaded.
// CONFIGURATION
//  JUMP_FETCH_CALL_EN defined:
//   - adds input is_call (latched with cond_ok) and output ld_xy (1).
//   - taken && is_call: INC2 -> SAVE (ld_xy=1 for one cycle, PC+2 saved as return address)
//     -> JMP. Taken-call latency is 9 cycles.
//  JUMP_FETCH_CALL_EN undefined:
//   - no is_call/ld_xy ports and no SAVE state; CALL cannot be issued through this block.
// TESTING
//  T1 pc_in=0x1000, mem 0x1000=0xAB, 0x1001=0xCD, ack same cycle, start+cond_ok=1 ->
//     ldJ1 with j_data=0xAB, ldJ2 with j_data=0xCD, 2 inc_pc, ld_pc_from_j, done at cycle 8.
//  T2 same as T1 with cond_ok=0 -> identical loads and 2 inc_pc, no ld_pc_from_j, done at cycle 7.
//  T3 mem_ack delayed 3 cycles on each read -> mem_rd and addr_out held stable for 4 cycles each;
//     done at cycle 14.
//  T4 start pulsed again during RD2, and mem_ack asserted while in LD1 -> both ignored,
//     one done only.
//  T5 rst_n=0 for one edge while in RD2 -> next cycle all outputs 0, state IDLE; a new start
//     then completes T1 normally.
//  T6 JUMP_FETCH_CALL_EN defined, is_call=1, cond_ok=1 -> ld_xy one cycle after INC2,
//     then ld_pc_from_j, done at cycle 9.

Source files
------------

// File: rtl/jump_addr_fetch_seq_if.sv
// Bus bundle between the jump-operand fetch sequencer, the decoder/memory and the J/PC register unit.
// JUMP_FETCH_CALL_EN adds the is_call qualifier and the ld_xy return-address strobe.
interface jump_addr_fetch_seq_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  logic          start;
  logic          cond_ok;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] addr_out;
  logic          addr_drv;
  logic          mem_rd;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] j_data;
  logic          ldJ1;
  logic          ldJ2;
  logic          inc_pc;
  logic          ld_pc_from_j;
  logic          busy;
  logic          done;
`ifdef JUMP_FETCH_CALL_EN
  logic          is_call;
  logic          ld_xy;
`endif

  modport master (
    output start, cond_ok, pc_in, mem_ack, mem_data,
`ifdef JUMP_FETCH_CALL_EN
    output is_call,
    input  ld_xy,
`endif
    input  addr_out, addr_drv, mem_rd, j_data, ldJ1, ldJ2, inc_pc, ld_pc_from_j, busy, done
  );

  modport slave (
    input  start, cond_ok, pc_in, mem_ack, mem_data,
`ifdef JUMP_FETCH_CALL_EN
    input  is_call,
    output ld_xy,
`endif
    output addr_out, addr_drv, mem_rd, j_data, ldJ1, ldJ2, inc_pc, ld_pc_from_j, busy, done
  );
endinterface

// File: rtl/jump_addr_fetch_seq.sv
// Fetches the two immediate bytes of a GOTO/CALL, strobes them into J1/J2, steps PC twice and
// optionally loads PC from {J1,J2}. JUMP_FETCH_CALL_EN adds the SAVE state for taken calls.
module jump_addr_fetch_seq #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jump_addr_fetch_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    RD1,
    LD1,
    INC1,
    RD2,
    LD2,
    INC2,
`ifdef JUMP_FETCH_CALL_EN
    SAVE,
`endif
    JMP,
    DONE
  } state_t;

  state_t        state, state_d;
  logic          taken, taken_d;
  logic [DW-1:0] j_data_q, j_data_d;
  logic          addr_drv_q, addr_drv_d;
  logic          mem_rd_q, mem_rd_d;
  logic          ldj1_q, ldj1_d;
  logic          ldj2_q, ldj2_d;
  logic          inc_pc_q, inc_pc_d;
  logic          ld_pc_q, ld_pc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef JUMP_FETCH_CALL_EN
  logic          call_q, call_d;
  logic          ld_xy_q, ld_xy_d;
`endif

  // Next state plus the output decode of that next state, so outputs line up with the state register
  always_comb begin
    state_d  = state;
    taken_d  = taken;
    j_data_d = j_data_q;
`ifdef JUMP_FETCH_CALL_EN
    call_d   = call_q;
`endif

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = RD1;
          taken_d = bus.cond_ok;
`ifdef JUMP_FETCH_CALL_EN
          call_d  = bus.is_call;
`endif
        end
      end
      RD1: begin
        if (bus.mem_ack) begin
          j_data_d = bus.mem_data;
          state_d  = LD1;
        end
      end
      LD1:  state_d = INC1;
      INC1: state_d = RD2;
      RD2: begin
        if (bus.mem_ack) begin
          j_data_d = bus.mem_data;
          state_d  = LD2;
        end
      end
      LD2:  state_d = INC2;
      INC2: begin
        if (taken) begin
`ifdef JUMP_FETCH_CALL_EN
          state_d = call_q ? SAVE : JMP;
`else
          state_d = JMP;
`endif
        end else begin
          state_d = DONE;
        end
      end
`ifdef JUMP_FETCH_CALL_EN
      SAVE: state_d = JMP;
`endif
      JMP:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_drv_d = (state_d == RD1) || (state_d == RD2);
    mem_rd_d   = (state_d == RD1) || (state_d == RD2);
    ldj1_d     = (state_d == LD1);
    ldj2_d     = (state_d == LD2);
    inc_pc_d   = (state_d == INC1) || (state_d == INC2);
    ld_pc_d    = (state_d == JMP);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
`ifdef JUMP_FETCH_CALL_EN
    ld_xy_d    = (state_d == SAVE);
`endif
  end

  // Reset drops any pending read and kills every strobe on the following cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      taken      <= 1'b0;
      j_data_q   <= '0;
      addr_drv_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      ldj1_q     <= 1'b0;
      ldj2_q     <= 1'b0;
      inc_pc_q   <= 1'b0;
      ld_pc_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef JUMP_FETCH_CALL_EN
      call_q     <= 1'b0;
      ld_xy_q    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      taken      <= taken_d;
      j_data_q   <= j_data_d;
      addr_drv_q <= addr_drv_d;
      mem_rd_q   <= mem_rd_d;
      ldj1_q     <= ldj1_d;
      ldj2_q     <= ldj2_d;
      inc_pc_q   <= inc_pc_d;
      ld_pc_q    <= ld_pc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef JUMP_FETCH_CALL_EN
      call_q     <= call_d;
      ld_xy_q    <= ld_xy_d;
`endif
    end
  end

  // PC changes at the INC1 edge, so the address must follow pc_in live rather than a stale copy
  assign bus.addr_out     = addr_drv_q ? bus.pc_in : AW'(0);
  assign bus.addr_drv     = addr_drv_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.j_data       = j_data_q;
  assign bus.ldJ1         = ldj1_q;
  assign bus.ldJ2         = ldj2_q;
  assign bus.inc_pc       = inc_pc_q;
  assign bus.ld_pc_from_j = ld_pc_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
`ifdef JUMP_FETCH_CALL_EN
  assign bus.ld_xy        = ld_xy_q;
`endif

endmodule
